// File: rtl/pwm_dac_pkg.sv
// Shared constants for the PWM DAC stage and anything that needs its period length.
// The period is 2^WIDTH-1 counts, so a full-scale duty value keeps the output high.
package pwm_dac_pkg;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int PWM_PERIOD(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler that emits a one-cycle tick every PRESCALE enabled clk cycles.
// The phase source upstream can reuse it to stay in step with the PWM counter.
module pwm_tick_gen
    import pwm_dac_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] presc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!en) begin
            presc_cnt <= '0;
        end else if (presc_cnt == LAST) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Gated by en so a PRESCALE of 1 does not tick while stopped.
    assign tick = en & (presc_cnt == LAST);

endmodule

// File: rtl/pwm_dac.sv
// Sample-to-PWM converter with a one-deep holding buffer; the duty value only
// changes on a period boundary (or immediately while the PWM is stopped).
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun,
    input  logic             clr_underrun
);

    localparam int PERIOD = PWM_PERIOD(WIDTH);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    logic             tick;
    logic             boundary;
    logic             transfer;
    logic             load_duty;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // valid/ready: a sample moves into hold on any clk edge where sample_valid
    // and sample_ready are both high; ready is simply "hold is empty".
    assign sample_ready = rst_n & ~hold_full;
    assign transfer     = sample_valid & sample_ready;
    assign boundary     = tick & (pwm_cnt == CNT_LAST);
    assign load_duty    = hold_full & (boundary | ~en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (!en) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= boundary ? '0 : pwm_cnt + 1'b1;
        end
    end

    // load_duty needs a full buffer and transfer an empty one, so they never collide;
    // a sample arriving on a boundary with hold empty therefore waits a full period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
            duty      <= '0;
        end else if (load_duty) begin
            duty      <= hold;
            hold_full <= 1'b0;
        end else if (transfer) begin
            hold      <= sample;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pwm_out      <= en & (pwm_cnt < duty);
            period_start <= boundary;
            if (boundary && !hold_full) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: default instance checked cycle by cycle against a
// small behavioural model, plus a PRESCALE=4 instance checked on period totals.
module tb_pwm_dac;

    localparam int PERIOD = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;
    logic       clr_underrun;

    logic       rst_n4;
    logic       en4;
    logic [7:0] sample4;
    logic       sample_valid4;
    logic       sample_ready4;
    logic       pwm_out4;
    logic       period_start4;
    logic       underrun4;
    logic       clr_underrun4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    logic [7:0] pend;
    logic       pend_v = 1'b0;
    logic [7:0] exp_duty = 8'd0;
    logic       exp_underrun = 1'b0;
    logic       exp_ps = 1'b0;
    int         mcnt = 0;
    int         hi_cnt = 0;
    int         win_duty = 0;

    always #5 clk = ~clk;

    pwm_dac u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    pwm_dac #(
        .PRESCALE (4)
    ) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n4),
        .en           (en4),
        .sample       (sample4),
        .sample_valid (sample_valid4),
        .sample_ready (sample_ready4),
        .pwm_out      (pwm_out4),
        .period_start (period_start4),
        .underrun     (underrun4),
        .clr_underrun (clr_underrun4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk cycle: update the model for the edge just passed, compare, then drive.
    task automatic step();
        @(negedge clk);
        if (!en) begin
            mcnt   = 0;
            exp_ps = 1'b0;
            if (exp_q.size() > 0) exp_duty = exp_q.pop_front();
        end else begin
            mcnt   = mcnt + 1;
            exp_ps = (mcnt == PERIOD);
            if (exp_ps) mcnt = 0;
        end
        if (exp_ps && exp_q.size() == 0) begin
            exp_underrun = 1'b1;
        end else begin
            if (exp_ps) exp_duty = exp_q.pop_front();
            if (clr_underrun) exp_underrun = 1'b0;
        end
        if (pend_v) begin
            exp_q.push_back(pend);
            pend_v = 1'b0;
        end
        check("period_start", 32'(period_start), 32'(exp_ps));
        check("underrun", 32'(underrun), 32'(exp_underrun));
        check("sample_ready", 32'(sample_ready), 32'(exp_q.size() == 0));
        if (!en) check("pwm_out_stopped", 32'(pwm_out), 32'd0);
        else hi_cnt += int'(pwm_out);
        if (exp_ps) begin
            check("high_count", 32'(hi_cnt), 32'(win_duty));
            hi_cnt   = 0;
            win_duty = int'(exp_duty);
        end
        if (stim_q.size() > 0) begin
            sample_valid = 1'b1;
            sample       = stim_q[0];
            if (exp_q.size() == 0) begin
                pend   = stim_q.pop_front();
                pend_v = 1'b1;
            end
        end else begin
            sample_valid = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_en(input logic v);
        en = v;
        if (v) begin
            hi_cnt   = 0;
            win_duty = int'(exp_duty);
        end
    endtask

    task automatic wait_ps4(output int n, output int hi);
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            hi += int'(pwm_out4);
        end while (!period_start4 && n < 1200);
    endtask

    initial begin
        int n4;
        int hi4;

        rst_n         = 1'b0;
        en            = 1'b0;
        sample        = 8'hAA;
        sample_valid  = 1'b1;
        clr_underrun  = 1'b0;
        rst_n4        = 1'b0;
        en4           = 1'b0;
        sample4       = 8'd0;
        sample_valid4 = 1'b0;
        clr_underrun4 = 1'b0;

        // reset held for three cycles with a sample offered
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm_out", 32'(pwm_out), 32'd0);
            check("rst_period_start", 32'(period_start), 32'd0);
            check("rst_underrun", 32'(underrun), 32'd0);
            check("rst_sample_ready", 32'(sample_ready), 32'd0);
        end
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        #1;
        check("ready_after_release", 32'(sample_ready), 32'd1);

        // preload 64 while stopped, then run with a fresh 64 every period
        stim_q.push_back(8'd64);
        run(4);
        set_en(1'b1);
        repeat (3) stim_q.push_back(8'd64);
        run(PERIOD * 3 + 5);

        // extremes: duty 0 then full scale across a boundary
        stim_q.push_back(8'd0);
        stim_q.push_back(8'd255);
        stim_q.push_back(8'd255);
        run(PERIOD * 3 + 5);

        // starve the buffer, then pulse clear, then hold clear across a boundary
        run(PERIOD * 2 + 10);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        run(10);
        clr_underrun = 1'b1;
        run(PERIOD + 45);
        clr_underrun = 1'b0;
        run(5);

        // back-pressure: valid stays high while three samples queue up
        stim_q.push_back(8'd10);
        stim_q.push_back(8'd20);
        stim_q.push_back(8'd30);
        run(PERIOD * 4);
        set_en(1'b0);
        run(5);

        // PRESCALE=4 instance
        @(negedge clk);
        rst_n4        = 1'b1;
        sample4       = 8'd128;
        sample_valid4 = 1'b1;
        @(negedge clk);
        sample_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        en4 = 1'b1;
        wait_ps4(n4, hi4);
        check("p4_first_period", 32'(n4), 32'd1020);
        check("p4_first_high", 32'(hi4), 32'd512);
        wait_ps4(n4, hi4);
        check("p4_period", 32'(n4), 32'd1020);
        check("p4_high_kept", 32'(hi4), 32'd512);
        check("p4_underrun", 32'(underrun4), 32'd1);
        repeat (300) @(negedge clk);
        rst_n4 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("p4_rst_pwm_out", 32'(pwm_out4), 32'd0);
            check("p4_rst_period_start", 32'(period_start4), 32'd0);
            check("p4_rst_underrun", 32'(underrun4), 32'd0);
            check("p4_rst_ready", 32'(sample_ready4), 32'd0);
        end
        rst_n4 = 1'b1;
        wait_ps4(n4, hi4);
        check("p4_restart_period", 32'(n4), 32'd1020);
        check("p4_restart_high", 32'(hi4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
